// File: rtl/wd_heartbeat_gen.sv
// Heartbeat generator for the shutdown watchdog: toggles hb_out while the control
// loop strobes alive_stb, freezes it on a stall, and latches watchdog trips.
module wd_heartbeat_gen #(
  parameter int unsigned HB_HALF_PERIOD = 50,
  parameter int unsigned ALIVE_TIMEOUT  = 100
) (
  input  logic       clk_1khz,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       alive_stb,
  input  logic       wd_trip,
  input  logic       fault_clr,
  output logic       hb_out,
  output logic       hb_active,
  output logic       fault,
  output logic [1:0] fault_cause
);

  localparam int unsigned HB_W = (HB_HALF_PERIOD > 1) ? $clog2(HB_HALF_PERIOD) : 1;
  localparam int unsigned AL_W = (ALIVE_TIMEOUT > 1) ? $clog2(ALIVE_TIMEOUT) : 1;
  localparam logic [HB_W-1:0] HB_LAST = HB_W'(HB_HALF_PERIOD - 1);
  localparam logic [AL_W-1:0] AL_LAST = AL_W'(ALIVE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_STALL,
    ST_SHUTDOWN
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'b00,
    CAUSE_STALL = 2'b01,
    CAUSE_TRIP  = 2'b10
  } cause_t;

  state_t          state_q, state_d;
  cause_t          cause_q, cause_d;
  logic [HB_W-1:0] hb_cnt_q, hb_cnt_d;
  logic [AL_W-1:0] alive_cnt_q, alive_cnt_d;
  logic            hb_q, hb_d;
  logic            hb_active_q, hb_active_d;
  logic            fault_q, fault_d;
  logic            trip_meta_q, trip_s_q;
  logic            run_hb;

  always_ff @(posedge clk_1khz) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cause_q     <= CAUSE_NONE;
      hb_cnt_q    <= '0;
      alive_cnt_q <= '0;
      hb_q        <= 1'b0;
      hb_active_q <= 1'b0;
      fault_q     <= 1'b0;
      trip_meta_q <= 1'b0;
      trip_s_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      hb_cnt_q    <= hb_cnt_d;
      alive_cnt_q <= alive_cnt_d;
      hb_q        <= hb_d;
      hb_active_q <= hb_active_d;
      fault_q     <= fault_d;
      trip_meta_q <= wd_trip;
      trip_s_q    <= trip_meta_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    hb_cnt_d    = hb_cnt_q;
    alive_cnt_d = alive_cnt_q;
    hb_d        = hb_q;
    fault_d     = fault_q;
    run_hb      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        hb_cnt_d    = '0;
        alive_cnt_d = '0;
        if (trip_s_q) begin
          state_d = ST_SHUTDOWN;
          fault_d = 1'b1;
          cause_d = CAUSE_TRIP;
        end else if (enable) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (trip_s_q) begin
          state_d     = ST_SHUTDOWN;
          fault_d     = 1'b1;
          cause_d     = CAUSE_TRIP;
          hb_cnt_d    = '0;
          alive_cnt_d = '0;
        end else if (!enable) begin
          state_d     = ST_IDLE;
          hb_cnt_d    = '0;
          alive_cnt_d = '0;
        end else if (alive_stb) begin
          alive_cnt_d = '0;
          run_hb      = 1'b1;
        end else if (alive_cnt_q == AL_LAST) begin
          // Heartbeat is frozen on the stall cycle itself, even if a toggle was due.
          state_d     = ST_STALL;
          fault_d     = 1'b1;
          cause_d     = CAUSE_STALL;
          hb_cnt_d    = '0;
          alive_cnt_d = '0;
        end else begin
          alive_cnt_d = alive_cnt_q + AL_W'(1);
          run_hb      = 1'b1;
        end

        if (run_hb) begin
          if (hb_cnt_q == HB_LAST) begin
            hb_d     = ~hb_q;
            hb_cnt_d = '0;
          end else begin
            hb_cnt_d = hb_cnt_q + HB_W'(1);
          end
        end
      end

      ST_STALL: begin
        if (trip_s_q) begin
          state_d = ST_SHUTDOWN;
          cause_d = CAUSE_TRIP;
        end else if (fault_clr) begin
          state_d = ST_IDLE;
          fault_d = 1'b0;
          cause_d = CAUSE_NONE;
        end
      end

      ST_SHUTDOWN: begin
        if (fault_clr && !trip_s_q) begin
          state_d = ST_IDLE;
          fault_d = 1'b0;
          cause_d = CAUSE_NONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    hb_active_d = (state_d == ST_RUN);
  end

  assign hb_out      = hb_q;
  assign hb_active   = hb_active_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;

endmodule

// File: tb/tb_wd_heartbeat_gen.sv
// Randomized bench for wd_heartbeat_gen, checked against a deadline-based model
// that tracks absolute edge numbers of RUN entry, last strobe and last toggle.
`timescale 1ns/1ps
module tb_wd_heartbeat_gen;

  localparam int HALF = 50;
  localparam int TMO  = 100;

  logic       clk_1khz = 1'b0;
  logic       rst_n, enable, alive_stb, wd_trip, fault_clr;
  logic       hb_out, hb_active, fault;
  logic [1:0] fault_cause;

  wd_heartbeat_gen #(.HB_HALF_PERIOD(HALF), .ALIVE_TIMEOUT(TMO)) dut (
    .clk_1khz   (clk_1khz),
    .rst_n      (rst_n),
    .enable     (enable),
    .alive_stb  (alive_stb),
    .wd_trip    (wd_trip),
    .fault_clr  (fault_clr),
    .hb_out     (hb_out),
    .hb_active  (hb_active),
    .fault      (fault),
    .fault_cause(fault_cause)
  );

  always #5 clk_1khz = ~clk_1khz;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  // Model: 0 idle, 1 run, 2 stall, 3 shutdown
  int   m_mode = 0;
  int   m_hb_ref = 0;
  int   m_alive_ref = 0;
  logic m_hb = 0, m_fault = 0;
  logic [1:0] m_cause = 0;
  logic trip_h1 = 0, trip_h2 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, obs, exp);
    end
  endtask

  task automatic model_step();
    logic trip;
    trip = trip_h2;
    if (!rst_n) begin
      m_mode = 0; m_hb = 0; m_fault = 0; m_cause = 0;
      trip_h1 = 0; trip_h2 = 0;
      return;
    end
    case (m_mode)
      0: begin
        if (trip) begin m_mode = 3; m_fault = 1; m_cause = 2; end
        else if (enable) begin m_mode = 1; m_hb_ref = edge_n; m_alive_ref = edge_n; end
      end
      1: begin
        if (trip) begin m_mode = 3; m_fault = 1; m_cause = 2; end
        else if (!enable) m_mode = 0;
        else if (!alive_stb && edge_n - m_alive_ref == TMO) begin
          m_mode = 2; m_fault = 1; m_cause = 1;
        end else begin
          if (alive_stb) m_alive_ref = edge_n;
          if (edge_n - m_hb_ref == HALF) begin m_hb = ~m_hb; m_hb_ref = edge_n; end
        end
      end
      2: begin
        if (trip) begin m_mode = 3; m_cause = 2; end
        else if (fault_clr) begin m_mode = 0; m_fault = 0; m_cause = 0; end
      end
      default: begin
        if (fault_clr && !trip) begin m_mode = 0; m_fault = 0; m_cause = 0; end
      end
    endcase
    trip_h2 = trip_h1;
    trip_h1 = wd_trip;
  endtask

  task automatic tick();
    @(posedge clk_1khz);
    edge_n++;
    model_step();
    #1;
    chk("hb_out", hb_out, m_hb);
    chk("hb_active", hb_active, m_mode == 1);
    chk("fault", fault, m_fault);
    chk("fault_cause", fault_cause, m_cause);
  endtask

  task automatic pulse_clr();
    fault_clr = 1; tick(); fault_clr = 0;
  endtask

  task automatic run_alive(input int cycles, input int every);
    for (int i = 0; i < cycles; i++) begin
      alive_stb = (every > 0) && ((i % every) == every - 1);
      tick();
    end
    alive_stb = 0;
  endtask

  initial begin
    int entry;
    logic loop_ok;
    rst_n = 0; enable = 0; alive_stb = 0; wd_trip = 0; fault_clr = 0;
    repeat (3) tick();
    chk("rst_hb", hb_out, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_cause", fault_cause, 2'b00);
    rst_n = 1;
    tick();

    // Healthy run: strobe every 20 cycles
    enable = 1;
    run_alive(1000, 20);
    chk("healthy_fault", fault, 1'b0);

    // Strobes stop -> stall
    run_alive(130, 0);
    chk("stall_cause", fault_cause, 2'b01);
    pulse_clr();
    chk("stall_clr_fault", fault, 1'b0);

    // Strobe every 99 cycles keeps the loop alive
    run_alive(600, 99);
    chk("strobe99_fault", fault, 1'b0);

    // Stall, then watchdog trips; clear ignored while trip held
    run_alive(120, 0);
    wd_trip = 1;
    repeat (3) tick();
    chk("trip_cause", fault_cause, 2'b10);
    pulse_clr();
    chk("clr_ignored", fault, 1'b1);
    wd_trip = 0;
    repeat (3) tick();
    enable = 0;
    pulse_clr();
    chk("trip_clr_fault", fault, 1'b0);
    tick();

    // Trip and alive timeout land on the same edge
    enable = 1;
    tick();
    entry = edge_n;
    while (edge_n < entry + 97) tick();
    wd_trip = 1;
    repeat (3) tick();
    chk("coincide_cause", fault_cause, 2'b10);
    wd_trip = 0;
    repeat (3) tick();
    pulse_clr();

    // Disable mid-count, then re-enter
    run_alive(80, 20);
    enable = 0;
    repeat (5) tick();
    enable = 1;
    run_alive(120, 20);

    // Reset while shut down
    wd_trip = 1;
    repeat (4) tick();
    rst_n = 0; wd_trip = 0;
    tick();
    chk("rst_sd_fault", fault, 1'b0);
    rst_n = 1;

    // Randomized phase
    loop_ok = 1;
    for (int i = 0; i < 6000; i++) begin
      rst_n     = ($urandom_range(0, 1499) != 0);
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      if ($urandom_range(0, 399) == 0) loop_ok = ~loop_ok;
      if ($urandom_range(0, 349) == 0) wd_trip = ~wd_trip;
      alive_stb = loop_ok && ($urandom_range(0, 29) == 0);
      fault_clr = ($urandom_range(0, 59) == 0);
      tick();
    end
    rst_n = 1; alive_stb = 0; fault_clr = 0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
